// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants, writeback grant type and arbitration helper
// Contents:
//   REG_ADDR_W : register index width
//   XLEN       : default datapath width
//   X0         : hardwired-zero register index
//   grant_t    : writeback arbitration result
//   arb_grant  : fixed-priority grant with starvation override
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_0    = 2'd1,
    GRANT_1    = 2'd2
  } grant_t;

  // Source 0 normally wins; source 1 wins when source 0 is idle or when it
  // has waited long enough that the starvation counter forces it through.
  function automatic grant_t arb_grant(input logic v0, input logic v1,
                                       input logic force_1);
    if (v1 && (force_1 || !v0)) return GRANT_1;
    else if (v0)                return GRANT_0;
    else                        return GRANT_NONE;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - two-source writeback request bundle
// Signals:
//   wb0_valid/wb0_ready/wb0_rd/wb0_data : ALU pipeline writeback
//   wb1_valid/wb1_ready/wb1_rd/wb1_data : long-latency unit writeback
// Modports:
//   master : requester side (drives valid/rd/data, observes ready)
//   slave  : arbiter side (observes valid/rd/data, drives ready)
interface regfile_wb_arbiter_if
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN
);

  logic                  wb0_valid;
  logic                  wb0_ready;
  logic [REG_ADDR_W-1:0] wb0_rd;
  logic [XLEN-1:0]       wb0_data;

  logic                  wb1_valid;
  logic                  wb1_ready;
  logic [REG_ADDR_W-1:0] wb1_rd;
  logic [XLEN-1:0]       wb1_data;

  modport master (
    output wb0_valid, wb0_rd, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_rd, wb1_data,
    input  wb1_ready
  );

  modport slave (
    input  wb0_valid, wb0_rd, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_rd, wb1_data,
    output wb1_ready
  );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write scoreboard for long-latency destinations
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   set_valid, set_rd   : long-latency op issued, destination to mark pending
//   clr_valid, clr_rd   : long-latency writeback accepted, destination to release
//   rs1_addr, rs2_addr  : decode-stage source registers
//   hazard              : either source has an outstanding write
module wb_scoreboard
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard
);

  localparam int NREG = 1 << REG_ADDR_W;

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask[set_rd] = 1'b1;
    if (clr_valid) clr_mask[clr_rd] = 1'b1;
    // Clear first, then set, so a re-issue in the same cycle as the
    // previous result returning keeps the register marked.
    pending_nxt = (pending & ~clr_mask) | set_mask;
    pending_nxt[X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign hazard = pending[rs1_addr] | pending[rs2_addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the regfile write port between ALU and long-latency writeback
// Optional feature macro: WB_SCOREBOARD_EN (pending-write scoreboard and RAW hazard output)
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   wb (slave)          : wb0_* ALU writeback, wb1_* long-latency writeback
//   issue_valid/rd      : long-latency op issued (scoreboard set)
//   rs1_addr/rs2_addr   : decode-stage sources checked for pending writes
//   hazard              : decode must stall
//   rf_rd_addr/rf_w_data/rf_w_en : registered regfile write port
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN         = cpu_pkg::XLEN,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_arbiter_if.slave   wb,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  hazard,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_w_data,
  output logic                  rf_w_en
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt;
  logic [3:0]            starve_cnt_nxt;
  logic                  force_1;
  grant_t                grant;
  logic                  xfer0;
  logic                  xfer1;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  assign force_1 = (starve_cnt == LIMIT);
  assign grant   = arb_grant(wb.wb0_valid, wb.wb1_valid, force_1);

  // Ready is gated by reset so neither requester sees an accept while held.
  assign wb.wb0_ready = rst_n && (grant == GRANT_0);
  assign wb.wb1_ready = rst_n && (grant == GRANT_1);

  assign xfer0 = wb.wb0_valid && wb.wb0_ready;
  assign xfer1 = wb.wb1_valid && wb.wb1_ready;

  always_comb begin
    starve_cnt_nxt = '0;
    if (wb.wb1_valid && !wb.wb1_ready)
      starve_cnt_nxt = force_1 ? starve_cnt : starve_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_nxt;
  end

  always_comb begin
    sel_rd   = wb.wb0_rd;
    sel_data = wb.wb0_data;
    if (xfer1) begin
      sel_rd   = wb.wb1_rd;
      sel_data = wb.wb1_data;
    end
  end

  // An x0 destination is still consumed; only the write strobe is suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en    <= 1'b0;
      rf_rd_addr <= '0;
      rf_w_data  <= '0;
    end else begin
      rf_w_en <= (xfer0 || xfer1) && (sel_rd != X0);
      if (xfer0 || xfer1) begin
        rf_rd_addr <= sel_rd;
        rf_w_data  <= sel_data;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (issue_valid && (issue_rd != X0)),
    .set_rd    (issue_rd),
    .clr_valid (xfer1 && (wb.wb1_rd != X0)),
    .clr_rd    (wb.wb1_rd),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .hazard    (hazard)
  );
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{issue_valid, issue_rd, rs1_addr, rs2_addr};
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        hazard;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_w_data;
  logic        rf_w_en;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter_if #(.XLEN(32)) wb_if ();

  regfile_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb          (wb_if),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .hazard      (hazard),
    .rf_rd_addr  (rf_rd_addr),
    .rf_w_data   (rf_w_data),
    .rf_w_en     (rf_w_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    wb_if.wb0_valid = 1'b0; wb_if.wb0_rd = '0; wb_if.wb0_data = '0;
    wb_if.wb1_valid = 1'b0; wb_if.wb1_rd = '0; wb_if.wb1_data = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_w_en", 32'(rf_w_en), 0);
    chk("rst_addr", 32'(rf_rd_addr), 0);
    chk("rst_data", rf_w_data, 0);
    chk("rst_hazard", 32'(hazard), 0);
    rst_n = 1'b1;

    // Single ALU write
    @(negedge clk);
    wb_if.wb0_valid = 1'b1; wb_if.wb0_rd = 5'd5; wb_if.wb0_data = 32'hDEAD_BEEF;
    #1;
    chk("alu_ready0", 32'(wb_if.wb0_ready), 1);
    chk("alu_ready1", 32'(wb_if.wb1_ready), 0);
    @(negedge clk);
    wb_if.wb0_valid = 1'b0;
    chk("alu_w_en", 32'(rf_w_en), 1);
    chk("alu_addr", 32'(rf_rd_addr), 5);
    chk("alu_data", rf_w_data, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("alu_w_en_drop", 32'(rf_w_en), 0);
    chk("alu_addr_hold", 32'(rf_rd_addr), 5);

    // Starvation: two passes, the second proves the counter restarted at 0
    for (int pass = 0; pass < 2; pass++) begin
      wb_if.wb1_valid = 1'b1;
      wb_if.wb1_rd    = 5'(7 + pass);
      wb_if.wb1_data  = 32'h7700 + 32'(pass);
      for (int c = 0; c < 4; c++) begin
        wb_if.wb0_valid = 1'b1;
        wb_if.wb0_rd    = 5'd3;
        wb_if.wb0_data  = 32'h100 + 32'(c);
        #1;
        chk("starve_ready0", 32'(wb_if.wb0_ready), (c < 3) ? 1 : 0);
        chk("starve_ready1", 32'(wb_if.wb1_ready), (c == 3) ? 1 : 0);
        @(negedge clk);
        if (c < 3) begin
          chk("starve_wr0_addr", 32'(rf_rd_addr), 3);
          chk("starve_wr0_data", rf_w_data, 32'h100 + 32'(c));
        end
      end
      chk("starve_wr1_en", 32'(rf_w_en), 1);
      chk("starve_wr1_addr", 32'(rf_rd_addr), 7 + pass);
      chk("starve_wr1_data", rf_w_data, 32'h7700 + 32'(pass));
    end
    wb_if.wb1_valid = 1'b0;
    #1;
    chk("resume_ready0", 32'(wb_if.wb0_ready), 1);
    @(negedge clk);
    wb_if.wb0_valid = 1'b0;

    // x0 destination: accepted, no write strobe
    wb_if.wb1_valid = 1'b1; wb_if.wb1_rd = 5'd0; wb_if.wb1_data = 32'd1;
    #1;
    chk("x0_ready1", 32'(wb_if.wb1_ready), 1);
    @(negedge clk);
    wb_if.wb1_valid = 1'b0;
    chk("x0_w_en", 32'(rf_w_en), 0);

    // Idle: a real write, then 5 idle cycles hold addr/data
    wb_if.wb0_valid = 1'b1; wb_if.wb0_rd = 5'd12; wb_if.wb0_data = 32'hCAFE_F00D;
    @(negedge clk);
    wb_if.wb0_valid = 1'b0;
    chk("pre_idle_w_en", 32'(rf_w_en), 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_ready0", 32'(wb_if.wb0_ready), 0);
      @(negedge clk);
      chk("idle_w_en", 32'(rf_w_en), 0);
      chk("idle_addr", 32'(rf_rd_addr), 12);
      chk("idle_data", rf_w_data, 32'hCAFE_F00D);
    end

    // Scoreboard
    issue_valid = 1'b1; issue_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0; rs1_addr = 5'd9;
    #1;
`ifdef WB_SCOREBOARD_EN
    chk("sb_rs1_hazard", 32'(hazard), 1);
    rs1_addr = 5'd0; rs2_addr = 5'd9;
    #1;
    chk("sb_rs2_hazard", 32'(hazard), 1);
    wb_if.wb1_valid = 1'b1; wb_if.wb1_rd = 5'd9; wb_if.wb1_data = 32'h99;
    #1;
    chk("sb_hold_during_xfer", 32'(hazard), 1);
    @(negedge clk);
    wb_if.wb1_valid = 1'b0;
    #1;
    chk("sb_cleared", 32'(hazard), 0);
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb_if.wb1_valid = 1'b1; wb_if.wb1_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0; wb_if.wb1_valid = 1'b0;
    #1;
    chk("sb_set_wins", 32'(hazard), 1);
`else
    chk("nosb_hazard", 32'(hazard), 0);
`endif

    // Async reset mid-stream with both requesters valid
    @(negedge clk);
    wb_if.wb0_valid = 1'b1; wb_if.wb0_rd = 5'd4; wb_if.wb0_data = 32'h44;
    wb_if.wb1_valid = 1'b1; wb_if.wb1_rd = 5'd6; wb_if.wb1_data = 32'h66;
    @(negedge clk);
    chk("pre_rst_w_en", 32'(rf_w_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_w_en", 32'(rf_w_en), 0);
    chk("mid_rst_addr", 32'(rf_rd_addr), 0);
    chk("mid_rst_ready0", 32'(wb_if.wb0_ready), 0);
    chk("mid_rst_ready1", 32'(wb_if.wb1_ready), 0);
    chk("mid_rst_hazard", 32'(hazard), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // Counter cleared by reset: source 0 wins again first
    chk("post_rst_ready0", 32'(wb_if.wb0_ready), 1);
    chk("post_rst_ready1", 32'(wb_if.wb1_ready), 0);
    @(negedge clk);
    wb_if.wb0_valid = 1'b0; wb_if.wb1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
